vidmem_wr_sched: RTL and testbench
==================================

Name: vidmem_wr_sched

Overview:
- Schedules the single write port of the video frame buffer (512x256 pixels, 12-bit RGB444) between two requesters: the CPU store path and the image coprocessor output stream.
- Each requester opens a frame transfer with a start pulse. The granted owner then holds the port exclusively until it signals done or the frame address wraps.
- The block generates the sequential write address and registers the write strobe and data toward the video memory.
- It sits between the CPU/coprocessor and the video memory, alongside the VGA timing read path.

Parameters:
- ADDR_W, 17, frame buffer address width (512*256 = 2^17 pixels).
- DATA_W, 12, pixel width (4 bits each for R, G, B).
- FRAME_PIX, 131072, number of pixels per frame; the last address is FRAME_PIX-1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- cpu_start  in  1  pulse; CPU requests a frame transfer.
- cpu_we  in  1  CPU pixel write strobe.
- cpu_wdata  in  DATA_W  CPU pixel data.
- cpu_done  in  1  pulse; CPU ends its transfer early.
- cpu_busy  out  1  high while CPU owns the port or has a pending request.
- cp_start  in  1  pulse; coprocessor requests a frame transfer.
- cp_valid  in  1  coprocessor pixel valid.
- cp_wdata  in  DATA_W  coprocessor pixel data.
- cp_last  in  1  qualifies the final coprocessor pixel (valid with ready).
- cp_ready  out  1  scheduler accepts a coprocessor pixel.
- mem_we  out  1  registered write enable to the video memory.
- mem_waddr  out  ADDR_W  registered write address.
- mem_wdata  out  DATA_W  registered write data.
- owner  out  2  current owner: 00 idle, 01 CPU, 10 coprocessor.
- frame_done  out  1  one-cycle pulse when a transfer ends.
- cpu_drop  out  1  sticky flag: a CPU write arrived while the CPU was not the owner.

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; all outputs 0; address counter 0; pending flags cleared; last_owner=CP, so the CPU wins the first tie.
- States: IDLE, CPU_XFER, CP_XFER.
- IDLE:
  - A start, or a pending flag, from one requester enters that requester's XFER state next cycle.
  - Simultaneous requests: the requester not equal to last_owner wins; the loser's pending flag is set.
  - On entry to XFER: counter=0, that pending flag is cleared, last_owner is updated.
- CPU_XFER:
  - Each cycle with cpu_we=1: mem_we=1, mem_waddr=counter, mem_wdata=cpu_wdata, all registered (1-cycle latency); counter then increments.
  - cp_ready=0 throughout.
- CP_XFER:
  - cp_ready=1 throughout.
  - A cp_valid&&cp_ready beat writes in the same way as a CPU write.
  - cp_valid=0 leaves a bubble: no write, counter holds.
- Transfer end, whichever comes first; the cause is not distinguished:
  - the owner's done (CPU) or an accepted cp_last beat (coprocessor);
  - an accepted write at counter==FRAME_PIX-1.
- On transfer end:
  - the final write still issues;
  - frame_done pulses on the cycle after that final write (aligned with its mem_we);
  - the state returns to IDLE; the counter wraps to 0 and does not advance past the wrap.
- Same-cycle write and cpu_done: the write is performed, then the transfer ends.
- Start from the non-owner while in XFER: its pending flag is set and it is served immediately after the current transfer, via IDLE (1 idle cycle minimum).
- Start from the owner while in XFER: the counter restarts at 0 and the transfer continues; there is no frame_done.
- CPU write outside CPU_XFER: the write is dropped (no mem_we) and cpu_drop is set. cpu_drop clears only on reset.
- cpu_busy = (owner==01) || cpu_pending.
- Counter width is ADDR_W, unsigned; there is no overflow beyond the wrap rule.
- Reset mid-transfer: writes abort immediately, mem_we=0 next cycle, and pending requests are lost.

Decomposition:
- Shared package vid_pkg holds:
  - the state enum;
  - the owner encoding constants OWN_IDLE, OWN_CPU, OWN_CP;
  - the ADDR_W, DATA_W and FRAME_PIX defaults.
- One natural sub-module, vidmem_addr_ctr: clear/increment/wrap counter with a last-address flag, shared by both XFER states.
- The FSM and the output registers stay in vidmem_wr_sched.

Test Plan:
- Reset, then cpu_start, then 4 cpu_we beats with data 0xF00, 0x0F0, 0x00F, 0xFFF, then cpu_done:
  - mem_we on 4 cycles, each one cycle after its beat, at waddr 0..3 with matching data;
  - frame_done pulses once; owner returns to 00.
- cpu_start and cp_start in the same cycle after reset:
  - CPU granted first (owner=01), coprocessor pending;
  - after cpu_done, owner goes 00 for 1 cycle, then 10.
  - Repeat with simultaneous starts: the coprocessor loses, i.e. round-robin is honoured.
- Coprocessor stream of 6 beats with cp_valid deasserted on beats 2 and 4, cp_last on the 4th accepted beat:
  - waddr 0..3 written, no writes in the bubble cycles;
  - frame_done one cycle after the final write.
- Coprocessor streams 131072 beats without cp_last:
  - last write at waddr 0x1FFFF;
  - frame_done pulses; owner returns to 00; the next beat is not accepted (cp_ready=0).
- cpu_we during CP_XFER with data 0xABC:
  - no mem_we with that data;
  - cpu_drop=1 and remains 1 until reset.
- rst_n low for one cycle mid-CPU transfer at waddr 50:
  - next cycle mem_we=0, owner=00, counter 0;
  - a following cpu_start writes from waddr 0.

Source files
------------

// File: rtl/vid_pkg.sv
// Shared types and default sizes for the video frame buffer write scheduler.
// Imported by the scheduler top and its address counter.
package vid_pkg;

  localparam int DEF_ADDR_W    = 17;
  localparam int DEF_DATA_W    = 12;
  localparam int DEF_FRAME_PIX = 131072;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CPU_XFER = 2'd1,
    ST_CP_XFER  = 2'd2
  } state_e;

  localparam logic [1:0] OWN_IDLE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_CP   = 2'b10;

endpackage

// File: rtl/vidmem_addr_ctr.sv
// Frame write address counter: synchronous clear, increment, and wrap to 0
// after the last pixel of the frame.
module vidmem_addr_ctr
  import vid_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int FRAME_PIX = DEF_FRAME_PIX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] cnt,
  output logic              last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIX - 1);

  assign last = (cnt == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= last ? '0 : cnt + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/vidmem_wr_sched.sv
// Arbitrates the frame buffer write port between the CPU store path and the
// coprocessor stream, generating sequential addresses and registered writes.
module vidmem_wr_sched
  import vid_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int FRAME_PIX = DEF_FRAME_PIX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_start,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_done,
  output logic              cpu_busy,
  input  logic              cp_start,
  input  logic              cp_valid,
  input  logic [DATA_W-1:0] cp_wdata,
  input  logic              cp_last,
  output logic              cp_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        owner,
  output logic              frame_done,
  output logic              cpu_drop
);

  state_e            state_q, state_d;
  logic              cpu_pend_q, cp_pend_q, cpu_drop_q;
  logic [1:0]        last_owner_q;
  logic              cpu_req, cp_req, grant_cpu, grant_cp;
  logic              wr_en, xfer_end, own_restart;
  logic              ctr_clr, ctr_inc, ctr_last;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] ctr;
  logic              vld_p1, fdone_p1;
  logic [ADDR_W-1:0] waddr_p1;
  logic [DATA_W-1:0] wdata_p1;

  vidmem_addr_ctr #(
    .ADDR_W   (ADDR_W),
    .FRAME_PIX(FRAME_PIX)
  ) u_ctr (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (ctr_clr),
    .inc  (ctr_inc),
    .cnt  (ctr),
    .last (ctr_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_cpu)     state_d = ST_CPU_XFER;
        else if (grant_cp) state_d = ST_CP_XFER;
      end
      ST_CPU_XFER, ST_CP_XFER: begin
        if (xfer_end) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A tie goes to whichever requester did not own the previous transfer.
  always_comb begin
    cpu_req     = cpu_start || cpu_pend_q;
    cp_req      = cp_start || cp_pend_q;
    grant_cpu   = 1'b0;
    grant_cp    = 1'b0;
    wr_en       = 1'b0;
    wr_data     = '0;
    xfer_end    = 1'b0;
    own_restart = 1'b0;
    ctr_clr     = 1'b0;
    ctr_inc     = 1'b0;
    owner       = OWN_IDLE;
    cp_ready    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req && cp_req) begin
          grant_cpu = (last_owner_q == OWN_CP);
          grant_cp  = (last_owner_q != OWN_CP);
        end else begin
          grant_cpu = cpu_req;
          grant_cp  = cp_req;
        end
        ctr_clr = grant_cpu || grant_cp;
      end
      ST_CPU_XFER: begin
        owner       = OWN_CPU;
        wr_en       = cpu_we;
        wr_data     = cpu_wdata;
        own_restart = cpu_start;
        xfer_end    = cpu_done || (cpu_we && ctr_last);
        ctr_clr     = xfer_end || own_restart;
        ctr_inc     = wr_en;
      end
      ST_CP_XFER: begin
        owner       = OWN_CP;
        cp_ready    = 1'b1;
        wr_en       = cp_valid;
        wr_data     = cp_wdata;
        own_restart = cp_start;
        xfer_end    = cp_valid && (cp_last || ctr_last);
        ctr_clr     = xfer_end || own_restart;
        ctr_inc     = wr_en;
      end
      default: ;
    endcase
    cpu_busy = (owner == OWN_CPU) || cpu_pend_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpu_pend_q   <= 1'b0;
      cp_pend_q    <= 1'b0;
      last_owner_q <= OWN_CP;
      cpu_drop_q   <= 1'b0;
    end else begin
      if (cpu_we && (state_q != ST_CPU_XFER)) cpu_drop_q <= 1'b1;
      if (state_q == ST_IDLE) begin
        cpu_pend_q <= cpu_req && !grant_cpu;
        cp_pend_q  <= cp_req && !grant_cp;
        if (grant_cpu)     last_owner_q <= OWN_CPU;
        else if (grant_cp) last_owner_q <= OWN_CP;
      end else begin
        if ((state_q != ST_CPU_XFER) && cpu_start) cpu_pend_q <= 1'b1;
        if ((state_q != ST_CP_XFER) && cp_start)   cp_pend_q  <= 1'b1;
      end
    end
  end

  // Stage p1: registered write toward the video memory.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      fdone_p1 <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
    end else begin
      vld_p1   <= wr_en;
      fdone_p1 <= xfer_end;
      if (wr_en) begin
        waddr_p1 <= ctr;
        wdata_p1 <= wr_data;
      end
    end
  end

  assign mem_we     = vld_p1;
  assign mem_waddr  = waddr_p1;
  assign mem_wdata  = wdata_p1;
  assign frame_done = fdone_p1;
  assign cpu_drop   = cpu_drop_q;

endmodule

// File: tb/tb_vidmem_wr_sched.sv
// Bench for vidmem_wr_sched: directed scenarios plus randomized traffic
// compared against a transfer-level reference model.
module tb_vidmem_wr_sched;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 12;
  localparam int FP     = 256;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cpu_start = 0, cpu_we = 0, cpu_done = 0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              cp_start = 0, cp_valid = 0, cp_last = 0;
  logic [DATA_W-1:0] cp_wdata = '0;
  logic              cpu_busy, cp_ready, mem_we, frame_done, cpu_drop;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [1:0]        owner;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vidmem_wr_sched #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAME_PIX(FP)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_start(cpu_start), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata), .cpu_done(cpu_done),
    .cpu_busy(cpu_busy),
    .cp_start(cp_start), .cp_valid(cp_valid), .cp_wdata(cp_wdata), .cp_last(cp_last),
    .cp_ready(cp_ready),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .owner(owner), .frame_done(frame_done), .cpu_drop(cpu_drop)
  );

  // Reference model: who owns the port (0 none, 1 CPU, 2 coprocessor),
  // who is waiting, and the pixel index of the next write.
  int m_own, m_last, m_addr;
  bit m_cpu_pend, m_cp_pend, m_drop;
  bit e_we, e_fd;
  int e_addr, e_data;

  function automatic void model_step();
    int win, bdata;
    bit cr, pr, beat, fin, ostart;
    e_we = 0;
    e_fd = 0;
    if (!rst_n) begin
      m_own = 0; m_last = 2; m_addr = 0;
      m_cpu_pend = 0; m_cp_pend = 0; m_drop = 0;
      return;
    end
    if (cpu_we && m_own != 1) m_drop = 1;
    if (m_own == 0) begin
      cr = cpu_start || m_cpu_pend;
      pr = cp_start || m_cp_pend;
      win = 0;
      if (cr && pr) win = (m_last == 1) ? 2 : 1;
      else if (cr)  win = 1;
      else if (pr)  win = 2;
      m_cpu_pend = cr && (win != 1);
      m_cp_pend  = pr && (win != 2);
      if (win != 0) begin
        m_own = win; m_last = win; m_addr = 0;
      end
    end else begin
      beat   = (m_own == 1) ? cpu_we : cp_valid;
      bdata  = (m_own == 1) ? int'(cpu_wdata) : int'(cp_wdata);
      ostart = (m_own == 1) ? cpu_start : cp_start;
      if (beat) begin
        e_we = 1; e_addr = m_addr; e_data = bdata;
      end
      fin = (beat && m_addr == FP - 1) || ((m_own == 1) ? cpu_done : (beat && cp_last));
      if (m_own == 1 && cp_start) m_cp_pend = 1;
      if (m_own == 2 && cpu_start) m_cpu_pend = 1;
      if (fin) begin
        e_fd = 1; m_own = 0; m_addr = 0;
      end else if (ostart) m_addr = 0;
      else if (beat) m_addr++;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    cpu_start = 0; cpu_we = 0; cpu_done = 0;
    cp_start = 0; cp_valid = 0; cp_last = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    step();
    rst_n = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    step();
    step();
    checks++;
    if ({mem_we, frame_done, cp_ready, cpu_busy, cpu_drop} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b exp 00000", {mem_we, frame_done, cp_ready, cpu_busy, cpu_drop});
    end
    checks++;
    if (owner !== 2'b00 || mem_waddr !== '0 || mem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_regs got owner=%0d addr=%0h data=%0h exp 0 0 0", owner, mem_waddr, mem_wdata);
    end
    rst_n = 1;
  endtask

  task automatic test_cpu_basic();
    logic [DATA_W-1:0] d [4];
    d[0] = 12'hF00; d[1] = 12'h0F0; d[2] = 12'h00F; d[3] = 12'hFFF;
    cpu_start = 1;
    step();
    cpu_start = 0;
    checks++;
    if (owner !== 2'b01 || cpu_busy !== 1'b1) begin
      errors++;
      $display("FAIL cpu_grant got owner=%0d busy=%0b exp 1 1", owner, cpu_busy);
    end
    for (int i = 0; i < 4; i++) begin
      cpu_we = 1; cpu_wdata = d[i];
      step();
      checks++;
      if (mem_we !== 1'b1 || mem_waddr !== ADDR_W'(i) || mem_wdata !== d[i] || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL cpu_write%0d got we=%0b addr=%0h data=%0h fd=%0b exp 1 %0h %0h 0",
                 i, mem_we, mem_waddr, mem_wdata, frame_done, i, d[i]);
      end
    end
    cpu_we = 0; cpu_done = 1;
    step();
    cpu_done = 0;
    checks++;
    if (mem_we !== 1'b0 || frame_done !== 1'b1 || owner !== 2'b00) begin
      errors++;
      $display("FAIL cpu_done got we=%0b fd=%0b owner=%0d exp 0 1 0", mem_we, frame_done, owner);
    end
    step();
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL fd_single_pulse got %0b exp 0", frame_done);
    end
  endtask

  task automatic test_arbitration();
    do_reset();
    cpu_start = 1; cp_start = 1;
    step();
    clear_inputs();
    checks++;
    if (owner !== 2'b01 || cp_ready !== 1'b0) begin
      errors++;
      $display("FAIL arb_tie1 got owner=%0d ready=%0b exp 1 0", owner, cp_ready);
    end
    cpu_done = 1;
    step();
    cpu_done = 0;
    checks++;
    if (owner !== 2'b00) begin
      errors++;
      $display("FAIL arb_gap got owner=%0d exp 0", owner);
    end
    step();
    checks++;
    if (owner !== 2'b10 || cp_ready !== 1'b1) begin
      errors++;
      $display("FAIL arb_cp_served got owner=%0d ready=%0b exp 2 1", owner, cp_ready);
    end
    cp_valid = 1; cp_last = 1;
    step();
    clear_inputs();
    cpu_start = 1; cp_start = 1;
    step();
    clear_inputs();
    checks++;
    if (owner !== 2'b01) begin
      errors++;
      $display("FAIL arb_tie2 got owner=%0d exp 1", owner);
    end
    cpu_done = 1;
    step();
    clear_inputs();
    step();
    cp_valid = 1; cp_last = 1;
    step();
    clear_inputs();
    cpu_start = 1;
    step();
    cpu_start = 0; cpu_done = 1;
    step();
    cpu_done = 0;
    cpu_start = 1; cp_start = 1;
    step();
    clear_inputs();
    checks++;
    if (owner !== 2'b10 || cpu_busy !== 1'b1) begin
      errors++;
      $display("FAIL arb_tie3 got owner=%0d busy=%0b exp 2 1", owner, cpu_busy);
    end
    cp_valid = 1; cp_last = 1;
    step();
    clear_inputs();
    step();
    checks++;
    if (owner !== 2'b01) begin
      errors++;
      $display("FAIL arb_cpu_after got owner=%0d exp 1", owner);
    end
    cpu_done = 1;
    step();
    cpu_done = 0;
    step();
  endtask

  task automatic test_cp_bubbles();
    bit vpat [6];
    int acc;
    vpat = '{1, 0, 1, 0, 1, 1};
    cp_start = 1;
    step();
    cp_start = 0;
    acc = 0;
    for (int b = 0; b < 6; b++) begin
      cp_valid = vpat[b];
      cp_wdata = DATA_W'(12'h100 + b);
      cp_last = (b == 5);
      step();
      checks++;
      if (vpat[b]) begin
        if (mem_we !== 1'b1 || mem_waddr !== ADDR_W'(acc) || mem_wdata !== DATA_W'(12'h100 + b)) begin
          errors++;
          $display("FAIL cp_beat%0d got we=%0b addr=%0h data=%0h exp 1 %0h %0h",
                   b, mem_we, mem_waddr, mem_wdata, acc, 12'h100 + b);
        end
        acc++;
      end else if (mem_we !== 1'b0) begin
        errors++;
        $display("FAIL cp_bubble%0d got we=%0b exp 0", b, mem_we);
      end
      checks++;
      if (frame_done !== (b == 5)) begin
        errors++;
        $display("FAIL cp_fd%0d got %0b exp %0b", b, frame_done, b == 5);
      end
    end
    clear_inputs();
    checks++;
    if (owner !== 2'b00) begin
      errors++;
      $display("FAIL cp_end_owner got %0d exp 0", owner);
    end
  endtask

  task automatic test_frame_wrap();
    int bad;
    cp_start = 1;
    step();
    cp_start = 0;
    bad = 0;
    for (int i = 0; i < FP; i++) begin
      cp_valid = 1;
      cp_wdata = DATA_W'($urandom_range(0, 4095));
      step();
      if (mem_we !== 1'b1 || mem_waddr !== ADDR_W'(i) || frame_done !== (i == FP - 1)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL wrap_stream got %0d bad beats exp 0", bad);
    end
    checks++;
    if (mem_waddr !== ADDR_W'(FP - 1) || frame_done !== 1'b1 || owner !== 2'b00 || cp_ready !== 1'b0) begin
      errors++;
      $display("FAIL wrap_end got addr=%0h fd=%0b owner=%0d ready=%0b exp %0h 1 0 0",
               mem_waddr, frame_done, owner, cp_ready, FP - 1);
    end
    step();
    checks++;
    if (mem_we !== 1'b0) begin
      errors++;
      $display("FAIL wrap_no_accept got we=%0b exp 0", mem_we);
    end
    clear_inputs();
  endtask

  task automatic test_cpu_drop();
    do_reset();
    cp_start = 1;
    step();
    cp_start = 0;
    cpu_we = 1; cpu_wdata = 12'hABC;
    step();
    cpu_we = 0;
    checks++;
    if (mem_we !== 1'b0 || cpu_drop !== 1'b1) begin
      errors++;
      $display("FAIL drop_set got we=%0b drop=%0b exp 0 1", mem_we, cpu_drop);
    end
    cp_valid = 1; cp_last = 1; cp_wdata = 12'h111;
    step();
    clear_inputs();
    checks++;
    if (mem_wdata !== 12'h111 || mem_waddr !== '0) begin
      errors++;
      $display("FAIL drop_cp_write got data=%0h addr=%0h exp 111 0", mem_wdata, mem_waddr);
    end
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (cpu_drop !== 1'b1) begin
      errors++;
      $display("FAIL drop_sticky got %0b exp 1", cpu_drop);
    end
    do_reset();
    #0;
    checks++;
    if (cpu_drop !== 1'b0) begin
      errors++;
      $display("FAIL drop_clear got %0b exp 0", cpu_drop);
    end
  endtask

  task automatic test_back_to_back();
    cpu_start = 1;
    step();
    cpu_start = 0;
    for (int i = 0; i < 3; i++) begin
      cpu_we = 1; cpu_wdata = DATA_W'(12'h200 + i);
      step();
    end
    cpu_start = 1; cp_start = 1; cpu_we = 1; cpu_wdata = 12'h333;
    step();
    cpu_start = 0; cp_start = 0;
    checks++;
    if (mem_we !== 1'b1 || mem_waddr !== ADDR_W'(3) || frame_done !== 1'b0 || owner !== 2'b01) begin
      errors++;
      $display("FAIL restart_write got we=%0b addr=%0h fd=%0b owner=%0d exp 1 3 0 1",
               mem_we, mem_waddr, frame_done, owner);
    end
    cpu_wdata = 12'h444;
    step();
    checks++;
    if (mem_waddr !== '0 || mem_wdata !== 12'h444) begin
      errors++;
      $display("FAIL restart_addr got addr=%0h data=%0h exp 0 444", mem_waddr, mem_wdata);
    end
    cpu_wdata = 12'h555; cpu_done = 1;
    step();
    clear_inputs();
    checks++;
    if (mem_we !== 1'b1 || mem_waddr !== ADDR_W'(1) || mem_wdata !== 12'h555 ||
        frame_done !== 1'b1 || owner !== 2'b00) begin
      errors++;
      $display("FAIL write_and_done got we=%0b addr=%0h data=%0h fd=%0b owner=%0d exp 1 1 555 1 0",
               mem_we, mem_waddr, mem_wdata, frame_done, owner);
    end
    step();
    checks++;
    if (owner !== 2'b10 || cp_ready !== 1'b1) begin
      errors++;
      $display("FAIL pend_cp_served got owner=%0d ready=%0b exp 2 1", owner, cp_ready);
    end
    cp_valid = 1; cp_last = 1;
    step();
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    cpu_start = 1;
    step();
    cpu_start = 0;
    for (int i = 0; i < 50; i++) begin
      cpu_we = 1; cpu_wdata = DATA_W'(i);
      cp_start = (i == 10);
      step();
    end
    cp_start = 0;
    checks++;
    if (mem_waddr !== ADDR_W'(49)) begin
      errors++;
      $display("FAIL mid_pre_addr got %0h exp 31", mem_waddr);
    end
    rst_n = 0; cpu_we = 1;
    step();
    rst_n = 1; cpu_we = 0;
    checks++;
    if (mem_we !== 1'b0 || owner !== 2'b00 || cpu_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got we=%0b owner=%0d busy=%0b exp 0 0 0", mem_we, owner, cpu_busy);
    end
    step();
    checks++;
    if (owner !== 2'b00) begin
      errors++;
      $display("FAIL mid_pend_lost got owner=%0d exp 0", owner);
    end
    cpu_start = 1;
    step();
    cpu_start = 0; cpu_we = 1; cpu_wdata = 12'h777;
    step();
    checks++;
    if (mem_we !== 1'b1 || mem_waddr !== '0 || mem_wdata !== 12'h777) begin
      errors++;
      $display("FAIL mid_restart got we=%0b addr=%0h data=%0h exp 1 0 777", mem_we, mem_waddr, mem_wdata);
    end
    cpu_we = 0; cpu_done = 1;
    step();
    clear_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      cpu_start = ($urandom_range(0, 19) == 0);
      cp_start  = ($urandom_range(0, 19) == 0);
      cpu_done  = ($urandom_range(0, 39) == 0);
      cpu_we    = ($urandom_range(0, 1) == 0);
      cp_valid  = ($urandom_range(0, 4) != 0);
      cp_last   = ($urandom_range(0, 49) == 0);
      cpu_wdata = DATA_W'($urandom_range(0, 4095));
      cp_wdata  = DATA_W'($urandom_range(0, 4095));
      step();
      checks++;
      if (mem_we !== e_we) begin
        errors++;
        $display("FAIL rnd_we cyc=%0d got %0b exp %0b", n, mem_we, e_we);
      end
      if (e_we) begin
        checks++;
        if (mem_waddr !== ADDR_W'(e_addr) || mem_wdata !== DATA_W'(e_data)) begin
          errors++;
          $display("FAIL rnd_write cyc=%0d got addr=%0h data=%0h exp %0h %0h",
                   n, mem_waddr, mem_wdata, e_addr, e_data);
        end
      end
      checks++;
      if (frame_done !== e_fd || owner !== 2'(m_own) || cp_ready !== (m_own == 2)) begin
        errors++;
        $display("FAIL rnd_ctrl cyc=%0d got fd=%0b owner=%0d ready=%0b exp %0b %0d %0b",
                 n, frame_done, owner, cp_ready, e_fd, m_own, m_own == 2);
      end
      checks++;
      if (cpu_busy !== (m_own == 1 || m_cpu_pend) || cpu_drop !== m_drop) begin
        errors++;
        $display("FAIL rnd_flags cyc=%0d got busy=%0b drop=%0b exp %0b %0b",
                 n, cpu_busy, cpu_drop, m_own == 1 || m_cpu_pend, m_drop);
      end
    end
    clear_inputs();
    rst_n = 1;
  endtask

  initial begin
    test_reset();
    test_cpu_basic();
    test_arbitration();
    test_cp_bubbles();
    test_frame_wrap();
    test_back_to_back();
    test_cpu_drop();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
